// File: rtl/clock_cal_pkg.sv
// clock_cal_pkg: shared types and helpers for the clock/calendar sequencer.
//   state_t          - sequencer FSM states
//   F_*              - field-select encodings used by set_field (6/7 are no-ops)
//   SEC_MAX/HOUR_MAX/MON_MAX - set-mode upper bounds
//   days_in_month()  - month length from month number and low two year bits
package clock_cal_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEC,
        ST_MIN,
        ST_HOUR,
        ST_DAY,
        ST_MON,
        ST_YEAR,
        ST_SET,
        ST_CLAMP
    } state_t;

    localparam logic [2:0] F_SEC  = 3'd0;
    localparam logic [2:0] F_MIN  = 3'd1;
    localparam logic [2:0] F_HOUR = 3'd2;
    localparam logic [2:0] F_DAY  = 3'd3;
    localparam logic [2:0] F_MON  = 3'd4;
    localparam logic [2:0] F_YEAR = 3'd5;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MON_MAX  = 6'd12;

    // Year is an offset from 2000, so year[1:0] == 0 is a leap year over
    // the whole 2000..2063 range (2000 itself is a leap year).
    function automatic logic [5:0] days_in_month(input logic [5:0] month,
                                                 input logic [1:0] year_lo);
        logic [5:0] d;
        case (month)
            6'd2:                      d = (year_lo == 2'd0) ? 6'd29 : 6'd28;
            6'd4, 6'd6, 6'd9, 6'd11:   d = 6'd30;
            default:                   d = 6'd31;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dim_lut.sv
// dim_lut: days-in-month lookup.
//   month  in  6  current month (1..12)
//   yr     in  2  low two bits of the year offset
//   dim    out 6  number of days in that month
module dim_lut
    import clock_cal_pkg::*;
(
    input  logic [5:0] month,
    input  logic [1:0] yr,
    output logic [5:0] dim
);

    assign dim = days_in_month(month, yr);

endmodule

// File: rtl/parallel_adder.sv
// parallel_adder: 6-bit adder shared by the sequencer (lives outside it).
//   a, y  in  6  operands
//   cin   in  1  carry-in
//   sum   out 6  a + y + cin (low 6 bits)
//   cout  out 1  carry-out
module parallel_adder (
    input  logic [5:0] a,
    input  logic [5:0] y,
    input  logic       cin,
    output logic [5:0] sum,
    output logic       cout
);

    assign {cout, sum} = 7'(a) + 7'(y) + 7'(cin);

endmodule

// File: rtl/clock_calendar_sequencer.sv
// clock_calendar_sequencer: owns the time/date registers and time-shares one
// external 6-bit adder across them. A 1 Hz tick ripples carries one field per
// cycle (sec->min->hour->day->month->year); user set requests bump a single
// field with no carry, followed by a day clamp after month/year changes.
//   clk, rst_n            clock, synchronous active-low reset
//   tick_1hz              one-cycle advance strobe
//   set_req/set_field/set_dir  level set request, field select, direction
//   add_a/add_y/add_cin   adder operands out; add_sum/add_cout adder result in
//   sec..year             current field values (year = offset from 2000)
//   set_ack               registered one-cycle ack of a set request
//   busy                  FSM not idle
//   tick_missed           sticky: a tick arrived while one was already pending
// Optional: define CLOCK_SET_DECREMENT_EN to honour set_dir = 1 (decrement).
module clock_calendar_sequencer
    import clock_cal_pkg::*;
#(
    parameter logic [5:0] YEAR_RST = 6'd0,
    parameter bit         TICK_PRI = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       set_req,
    input  logic [2:0] set_field,
    input  logic       set_dir,
    output logic [5:0] add_a,
    output logic [5:0] add_y,
    output logic       add_cin,
    input  logic [5:0] add_sum,
    input  logic       add_cout,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [5:0] hour,
    output logic [5:0] day,
    output logic [5:0] month,
    output logic [5:0] year,
    output logic       set_ack,
    output logic       busy,
    output logic       tick_missed
);

    state_t     state, state_n;
    logic       tick_pend;
    logic [2:0] fld, fsel, wr_fld;
    logic [5:0] dim, cur, lim, hi, lo, wr_val;
    logic       wr_en, tick_go, set_go, dec;

`ifdef CLOCK_SET_DECREMENT_EN
    logic fdir;
    assign dec = fdir;
`else
    logic unused_set_dir;
    assign unused_set_dir = set_dir;
    assign dec = 1'b0;
`endif

    dim_lut u_dim (.month(month), .yr(year[1:0]), .dim(dim));

    // A tick can be taken straight from tick_1hz so the ripple starts the
    // very next cycle; a pending tick is served the same way.
    assign tick_go = (tick_1hz | tick_pend) & (TICK_PRI | ~set_req);
    assign set_go  = set_req & ~tick_go;
    assign busy    = (state != ST_IDLE);

    // Field being operated on: fixed by state during a ripple, latched
    // request field during SET/CLAMP.
    always_comb begin
        fsel = fld;
        case (state)
            ST_SEC:  fsel = F_SEC;
            ST_MIN:  fsel = F_MIN;
            ST_HOUR: fsel = F_HOUR;
            ST_DAY:  fsel = F_DAY;
            ST_MON:  fsel = F_MON;
            ST_YEAR: fsel = F_YEAR;
            default: fsel = fld;
        endcase
    end

    // Current value and set-mode bounds of the selected field.
    always_comb begin
        cur = 6'd0;
        hi  = 6'd63;
        lo  = 6'd0;
        case (fsel)
            F_SEC:   begin cur = sec;   hi = SEC_MAX;  end
            F_MIN:   begin cur = min;   hi = SEC_MAX;  end
            F_HOUR:  begin cur = hour;  hi = HOUR_MAX; end
            F_DAY:   begin cur = day;   hi = dim;     lo = 6'd1; end
            F_MON:   begin cur = month; hi = MON_MAX; lo = 6'd1; end
            F_YEAR:  begin cur = year;  end
            default: begin cur = 6'd0;  end
        endcase
    end

    always_comb begin
        state_n = state;
        add_a   = 6'd0;
        add_y   = 6'd0;
        add_cin = 1'b0;
        wr_en   = 1'b0;
        wr_fld  = fsel;
        wr_val  = add_sum;
        lim     = 6'd0;

        case (state)
            ST_SEC, ST_MIN: lim = 6'd60;
            ST_HOUR:        lim = 6'd24;
            ST_DAY:         lim = dim + 6'd1;
            ST_MON:         lim = 6'd13;
            default:        lim = 6'd0;
        endcase

        case (state)
            ST_IDLE: begin
                if (tick_go)     state_n = ST_SEC;
                else if (set_go) state_n = ST_SET;
            end
            ST_SEC, ST_MIN, ST_HOUR, ST_DAY, ST_MON: begin
                wr_en = 1'b1;
                if (add_sum == lim) begin
                    // Carry out of this field: write its wrap value (lo) and
                    // move on to the next field.
                    wr_val = lo;
                    case (state)
                        ST_SEC:  state_n = ST_MIN;
                        ST_MIN:  state_n = ST_HOUR;
                        ST_HOUR: state_n = ST_DAY;
                        ST_DAY:  state_n = ST_MON;
                        default: state_n = ST_YEAR;
                    endcase
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_YEAR: begin
                wr_en   = 1'b1;
                wr_val  = add_cout ? 6'd0 : add_sum;
                state_n = ST_IDLE;
            end
            ST_SET: begin
                wr_en = (fld <= F_YEAR);
                if (dec) wr_val = (cur == lo) ? hi : add_sum;
                else     wr_val = (cur == hi) ? lo : add_sum;
                // Month/year changes can leave day past the new month end.
                state_n = (fld == F_MON || fld == F_YEAR) ? ST_CLAMP : ST_IDLE;
            end
            ST_CLAMP: begin
                wr_fld  = F_DAY;
                wr_en   = (day > dim);
                wr_val  = dim;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        if (state != ST_IDLE) begin
            add_a = cur;
            add_y = 6'd1;
            if (state == ST_SET && dec) begin
                add_y   = 6'b111110;
                add_cin = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sec         <= 6'd0;
            min         <= 6'd0;
            hour        <= 6'd0;
            day         <= 6'd1;
            month       <= 6'd1;
            year        <= YEAR_RST;
            set_ack     <= 1'b0;
            tick_missed <= 1'b0;
            tick_pend   <= 1'b0;
            fld         <= F_SEC;
`ifdef CLOCK_SET_DECREMENT_EN
            fdir        <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            set_ack     <= (state == ST_SET && state_n == ST_IDLE) || (state == ST_CLAMP);
            tick_missed <= tick_missed | (tick_1hz & tick_pend);
            // When a tick is served, a pending one is consumed and a fresh
            // tick in the same cycle (if any) stays pending.
            if (state == ST_IDLE && tick_go) tick_pend <= tick_pend & tick_1hz;
            else                             tick_pend <= tick_pend | tick_1hz;
            if (state == ST_IDLE && set_go) begin
                fld <= set_field;
`ifdef CLOCK_SET_DECREMENT_EN
                fdir <= set_dir;
`endif
            end
            if (wr_en) begin
                case (wr_fld)
                    F_SEC:   sec   <= wr_val;
                    F_MIN:   min   <= wr_val;
                    F_HOUR:  hour  <= wr_val;
                    F_DAY:   day   <= wr_val;
                    F_MON:   month <= wr_val;
                    F_YEAR:  year  <= wr_val;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/clock_calendar_sequencer.md
Name: clock_calendar_sequencer

Overview:
- Owns the time/date registers of the digital clock and sequences one shared 6-bit ripple adder (parallel_adder, external) across all fields.
- Each 1 Hz tick ripples carries seconds→minutes→hours→day→month→year, one field per cycle.
- Arbitrates user "set" requests (increment one field, no carry) against ticks.
- Handles month lengths and leap years.

Parameters:
- YEAR_RST, 0, reset year offset (actual year = 2000 + year).
- TICK_PRI, 1, 1 = a pending tick beats a set request in IDLE; 0 = the set request wins.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- tick_1hz  in  1  one-cycle advance strobe
- set_req  in  1  user adjust request, level
- set_field  in  3  field to adjust: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year; 6–7 no-op
- set_dir  in  1  0 = +1, 1 = −1 (only with DECREMENT_EN)
- add_a  out  6  adder operand A
- add_y  out  6  adder operand Y
- add_cin  out  1  adder carry-in
- add_sum  in  6  adder Data, combinational from add_a/add_y/add_cin
- add_cout  in  1  adder Cout
- sec, min, hour, day, month, year  out  6 each  current values
- set_ack  out  1  one-cycle pulse, registered
- busy  out  1  FSM not in IDLE
- tick_missed  out  1  sticky overflow flag

Behaviour:
- Reset (rst_n = 0 at a clk edge): sec = min = hour = 0; day = 1; month = 1; year = YEAR_RST; set_ack = 0; busy = 0; tick_missed = 0; tick_pend = 0; state = IDLE. Reset mid-ripple aborts the ripple; no partial carry survives.
- States: IDLE, SEC, MIN, HOUR, DAY, MON, YEAR, SET, CLAMP.
- Adder drive:
  - add_a = selected field, add_y = 6'd1, add_cin = 0 in every active state.
  - In IDLE: add_a = add_y = 0, add_cin = 0.
- Tick path:
  - tick_1hz sets tick_pend.
  - In IDLE with tick_pend set: clear it, go to SEC. Tick at cycle t in IDLE → SEC at t+1 → sec updated at the edge ending t+1.
- Wrap limits per state. If add_sum equals the limit, write the wrap value and advance to the next state; otherwise write add_sum and return to IDLE.
  - SEC: limit 60, wrap 0.
  - MIN: limit 60, wrap 0.
  - HOUR: limit 24, wrap 0.
  - DAY: limit dim+1, wrap 1.
  - MON: limit 13, wrap 1.
  - YEAR: write add_sum (63→0 via add_cout), then IDLE.
- Month lengths (dim): 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; February is 29 if year[1:0] == 0, else 28.
- Ripple length: at most 6 active cycles (SEC..YEAR).
- Tick overflow: tick_1hz while tick_pend is already 1 sets tick_missed (cleared only by reset). A tick arriving while busy is held in tick_pend, not lost.
- Set path:
  - In IDLE with set_req = 1 (subject to TICK_PRI), latch set_field/set_dir and go to SET.
  - SET writes the field with set-mode wrap and no carry:
    - sec/min: 59→0.
    - hour: 23→0.
    - day: dim→1.
    - month: 12→1.
    - year: 63→0.
  - set_ack pulses in the cycle after SET.
  - Fields 6/7: no write, set_ack still pulses.
  - After a month or year set, go through CLAMP: if day > new dim, day = dim. CLAMP adds one cycle; set_ack is then issued after CLAMP.
  - set_req still high in the cycle after set_ack counts as a new request. Requesters must drop it on ack.
- Simultaneous tick_1hz and set_req in IDLE: resolved by TICK_PRI; the loser waits in IDLE.

Optional Feature:
- Macro: CLOCK_SET_DECREMENT_EN.
- Defined: set_dir = 1 drives add_y = 6'b111110, add_cin = 1 (A − 1 mod 64). Underflow wraps:
  - sec/min 0→59, hour 0→23, year 0→63.
  - day 1→dim, month 1→12, followed by CLAMP.
- Undefined: set_dir ignored; always increments.

Decomposition:
- Package clock_cal_pkg holds:
  - the state enum;
  - field-select encodings;
  - constants SEC_MAX = 59, HOUR_MAX = 23, MON_MAX = 12;
  - a days_in_month(month, year) function.
- One natural sub-module: dim_lut (month, year[1:0] → dim), shared by the DAY and CLAMP states.
- The adder stays outside this block; the bench instantiates parallel_adder.

Test Plan:
- 00:00:59, tick → 00:01:00; busy high for exactly 2 cycles.
- 2024-02-28 23:59:59 (year = 24), tick → 2024-02-29 00:00:00. Same stimulus with year = 23 → 2023-03-01.
- 2023-12-31 23:59:59, tick → 2024-01-01 00:00:00 after 6 active cycles. Second tick mid-ripple → applied afterward; tick_missed stays 0.
- day = 31, month = 1, year = 23; set month → month = 2, day = 28 after CLAMP; single set_ack pulse.
- Three ticks within one ripple → tick_missed = 1. rst_n low mid-ripple → all fields at reset values next cycle.
- With CLOCK_SET_DECREMENT_EN: set year, dir = 1, at year 0 → 63. Set month, dir = 1, at month 1 → 12.
